// File: rtl/overture_cpu_pkg.sv
// overture_cpu_pkg: opcode encoding and an instruction-word builder for the Overture accumulator CPU
package overture_cpu_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    OP_NOP, OP_LOADI, OP_ADDI, OP_SUBI, OP_JMP, OP_JZ, OP_OUT, OP_HALT
  } opcode_e;
  function automatic logic [34:0] instr_word(opcode_e op, logic [31:0] imm, int unsigned data_w = 8);
    return (35'(op) << data_w) | (35'(imm) & ((35'd1 << data_w) - 35'd1));
  endfunction
endpackage

// File: rtl/overture_prog_mem.sv
// overture_prog_mem: program store with one synchronous write port and one asynchronous read port
module overture_prog_mem #(
  parameter int DEPTH = 16,
  parameter int W = 11,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/overture_cpu_seq.sv
// overture_cpu_seq: single-issue accumulator CPU executing one instruction per enabled clock
module overture_cpu_seq
  import overture_cpu_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int PROG_DEPTH = 16,
  localparam int PC_W = $clog2(PROG_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   step,
  input  logic                   prog_we,
  input  logic [PC_W-1:0]        prog_addr,
  input  logic [OP_W+DATA_W-1:0] prog_data,
  output logic [PC_W-1:0]        pc,
  output logic [DATA_W-1:0]      acc,
  output logic                   carry,
  output logic                   zero,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   halted
);
  logic [PC_W-1:0]        r_pc, w_pc_nxt, w_pc_inc;
  logic [DATA_W-1:0]      r_acc, w_acc_nxt, r_out, w_out_nxt, w_imm;
  logic                   r_carry, w_carry_nxt, r_valid, w_valid_nxt, r_halted, w_halted_nxt;
  logic                   w_exec;
  logic [OP_W+DATA_W-1:0] w_instr;
  logic [DATA_W:0]        w_sum, w_diff;
  opcode_e                w_op;

  overture_prog_mem #(.DEPTH(PROG_DEPTH), .W(OP_W+DATA_W), .AW(PC_W)) u_mem (
    .clk(clk), .i_we(prog_we), .i_waddr(prog_addr), .i_wdata(prog_data),
    .i_raddr(r_pc), .o_rdata(w_instr)
  );

  assign w_op     = opcode_e'(w_instr[OP_W+DATA_W-1:DATA_W]);
  assign w_imm    = w_instr[DATA_W-1:0];
  assign w_exec   = !r_halted && (run || step);
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_imm};
  // the MSB of the extended difference is the borrow, i.e. imm > acc
  assign w_diff   = {1'b0, r_acc} - {1'b0, w_imm};

  always_comb begin
    w_pc_nxt     = r_pc;
    w_acc_nxt    = r_acc;
    w_carry_nxt  = r_carry;
    w_out_nxt    = r_out;
    w_valid_nxt  = 1'b0;
    w_halted_nxt = r_halted;
    if (w_exec) begin
      w_pc_nxt = w_pc_inc;
      case (w_op)
        OP_NOP:   ;
        OP_LOADI: w_acc_nxt = w_imm;
        OP_ADDI:  {w_carry_nxt, w_acc_nxt} = w_sum;
        OP_SUBI:  {w_carry_nxt, w_acc_nxt} = w_diff;
        OP_JMP:   w_pc_nxt = w_imm[PC_W-1:0];
        OP_JZ:    w_pc_nxt = (r_acc == '0) ? w_imm[PC_W-1:0] : w_pc_inc;
        OP_OUT:   begin w_out_nxt = r_acc; w_valid_nxt = 1'b1; end
        OP_HALT:  begin w_pc_nxt = r_pc; w_halted_nxt = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_out    <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_acc    <= w_acc_nxt;
      r_carry  <= w_carry_nxt;
      r_out    <= w_out_nxt;
      r_valid  <= w_valid_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  assign pc        = r_pc;
  assign acc       = r_acc;
  assign carry     = r_carry;
  assign zero      = (r_acc == '0);
  assign out_data  = r_out;
  assign out_valid = r_valid;
  assign halted    = r_halted;
endmodule

// File: tb/tb_overture_cpu_seq.sv
// tb_overture_cpu_seq: directed self-checking bench for overture_cpu_seq
module tb_overture_cpu_seq;
  import overture_cpu_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1, run = 1'b0, step = 1'b0, prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [10:0] prog_data = '0;
  logic [3:0]  pc;
  logic [7:0]  acc, out_data;
  logic        carry, zero, out_valid, halted;
  int          passed = 0, total = 0;
  logic [7:0]  step_acc [3] = '{8'd3, 8'd8, 8'd10};

  overture_cpu_seq #(.DATA_W(8), .PROG_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .pc(pc), .acc(acc),
    .carry(carry), .zero(zero), .out_data(out_data), .out_valid(out_valid),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [10:0] iw(opcode_e op, int imm);
    return 11'(instr_word(op, 32'(imm)));
  endfunction

  task automatic wr(input int a, input logic [10:0] d);
    prog_we = 1'b1;
    prog_addr = 4'(a);
    prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic restart();
    run = 1'b0;
    step = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    wr(0, iw(OP_LOADI, 3)); wr(1, iw(OP_ADDI, 5)); wr(2, iw(OP_ADDI, 2)); wr(3, iw(OP_HALT, 0));
    restart();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_zero", 32'(zero), 1);
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_halt", 32'(halted), 0);
    run = 1'b1;
    tick(); chk("p1_e1_acc", 32'(acc), 3);
    tick(); chk("p1_e2_acc", 32'(acc), 8);
    tick(); chk("p1_e3_acc", 32'(acc), 10);
    tick(); chk("p1_e4_halt", 32'(halted), 1);
    chk("p1_e4_pc", 32'(pc), 3);
    repeat (5) tick();
    chk("p1_hold_pc", 32'(pc), 3);
    chk("p1_hold_acc", 32'(acc), 10);
    chk("p1_hold_halt", 32'(halted), 1);

    restart();
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("step_acc", 32'(acc), 32'(step_acc[i]));
      tick(); tick();
      chk("step_hold_acc", 32'(acc), 32'(step_acc[i]));
      chk("step_ov", 32'(out_valid), 0);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_halt", 32'(halted), 1);

    restart();
    run = 1'b1;
    tick(); tick();
    chk("mid_acc", 32'(acc), 8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_pc", 32'(pc), 0);
    chk("mid_rst_acc", 32'(acc), 0);
    chk("mid_rst_halt", 32'(halted), 0);
    repeat (4) tick();
    chk("mid_rerun_acc", 32'(acc), 10);
    chk("mid_rerun_halt", 32'(halted), 1);

    run = 1'b0;
    wr(0, iw(OP_LOADI, 3)); wr(1, iw(OP_SUBI, 1)); wr(2, iw(OP_JZ, 4));
    wr(3, iw(OP_JMP, 1)); wr(4, iw(OP_OUT, 0)); wr(5, iw(OP_HALT, 0));
    restart();
    run = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      chk($sformatf("p2_e%0d_ov", e), 32'(out_valid), (e == 10) ? 1 : 0);
      chk($sformatf("p2_e%0d_halt", e), 32'(halted), (e == 11) ? 1 : 0);
      if (e == 10) chk("p2_out_data", 32'(out_data), 0);
    end
    chk("p2_pc", 32'(pc), 5);

    run = 1'b0;
    wr(0, iw(OP_LOADI, 250)); wr(1, iw(OP_ADDI, 10)); wr(2, iw(OP_SUBI, 5)); wr(3, iw(OP_HALT, 0));
    restart();
    run = 1'b1;
    tick(); chk("p3_e1_acc", 32'(acc), 250); chk("p3_e1_c", 32'(carry), 0);
    tick(); chk("p3_e2_acc", 32'(acc), 4);   chk("p3_e2_c", 32'(carry), 1);
    tick(); chk("p3_e3_acc", 32'(acc), 255); chk("p3_e3_c", 32'(carry), 1);

    run = 1'b0;
    wr(0, iw(OP_LOADI, 0)); wr(1, iw(OP_NOP, 0)); wr(2, iw(OP_JZ, 4));
    wr(3, iw(OP_HALT, 0)); wr(4, iw(OP_LOADI, 1)); wr(5, iw(OP_JMP, 1));
    restart();
    run = 1'b1;
    tick();
    chk("wf_e1_pc", 32'(pc), 1);
    prog_we = 1'b1;
    prog_addr = 4'd1;
    prog_data = iw(OP_ADDI, 7);
    tick();
    prog_we = 1'b0;
    chk("wf_old_acc", 32'(acc), 0);
    chk("wf_old_pc", 32'(pc), 2);
    repeat (4) tick();
    chk("wf_new_acc", 32'(acc), 8);
    chk("wf_new_pc", 32'(pc), 2);
    repeat (2) tick();
    chk("wf_halt", 32'(halted), 1);
    chk("wf_halt_pc", 32'(pc), 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
